// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and UART frame timing for the tx arbiter and future rx dispatcher.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT} state_t;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_FRAME_MARGIN = 16;
  localparam int UART_FRAME_CYCLES = UART_OVERSAMPLE * UART_FRAME_BITS + UART_FRAME_MARGIN;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_rr_select.sv
// uart_rr_select: picks a pending requester, round-robin after ptr, or lowest index when UART_TX_ARB_FIXED_PRIO_EN is defined.
module uart_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
`ifndef UART_TX_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]      ptr,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [IW-1:0]      sel,
  output logic               valid
);
  assign valid = |req;
  always_comb begin
    sel = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) sel = IW'(i);
`else
    // Walk from farthest to nearest so the first set request after ptr wins.
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) sel = IW'((int'(ptr) + k) % NUM_REQ);
`endif
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uarttx among NUM_REQ byte producers; UART_TX_ARB_FIXED_PRIO_EN selects fixed priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int FRAME_CYCLES = UART_FRAME_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic [7:0]                 datain,
  output logic                       wrsig,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(imax(STROBE_CYCLES, FRAME_CYCLES) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] sel;
  logic valid;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr;
`endif
  uart_rr_select #(.NUM_REQ(NUM_REQ), .IW(IW)) u_sel (
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    .ptr(ptr),
`endif
    .req(req),
    .sel(sel),
    .valid(valid)
  );
  // The transmitter has no done flag, so WAIT blindly covers a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ack <= '0;
      grant <= '0;
      datain <= 8'h00;
      wrsig <= 1'b0;
      busy <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      ptr <= IW'(NUM_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: if (valid) begin
          state <= LOAD;
          grant <= sel;
          datain <= data[8*sel +: 8];
          ack <= NUM_REQ'(1) << sel;
          busy <= 1'b1;
          cnt <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
          ptr <= sel;
`endif
        end
        LOAD: begin
          state <= STROBE;
          ack <= '0;
          wrsig <= 1'b1;
          cnt <= '0;
        end
        STROBE: if (cnt == CW'(STROBE_CYCLES - 1)) begin
          state <= WAIT;
          wrsig <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        WAIT: if (cnt == CW'(FRAME_CYCLES - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
